dec_ctrl: RTL
=============

# dec_ctrl

Decode-stage pipeline controller for the two-way decode bundle. It sits between fetch and the two `dec_way` instances. It generates the shared `pipe_load_decode` enable and tracks bundle and per-way validity through a valid/ready handshake with issue. It also masks ways younger than an illegal instruction and holds an exception request until the front end is flushed.

## Interface
Parameters:
- `WAYS`, 2: decode ways per bundle; the design is fixed at 2.
- `CNT_W`, 32: width of the stall counter.

Ports:
- `clock`  in  1: core clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `fetch_valid_i`  in  1: fetch presents a bundle.
- `fetch_way_vld_i`  in  2: per-way instruction valid within the fetched bundle.
- `fetch_ready_o`  out  1: decode accepts the bundle this cycle.
- `pipe_load_decode_o`  out  1: load enable to both `dec_way` instances.
- `illegal_inst_r0_i`  in  2: registered illegal flag from way0/way1.
- `dec_valid_o`  out  1: decoded bundle held in r0.
- `dec_way_vld_r0_o`  out  2: registered way-valid copy of `fetch_way_vld_i`.
- `issue_vld_o`  out  2: ways allowed to issue.
- `issue_ready_i`  in  1: issue consumes the r0 bundle.
- `flush_i`  in  1: front-end redirect/flush.
- `exc_req_o`  out  1: illegal-instruction exception pending.
- `exc_way_o`  out  1: way index of the oldest illegal instruction.
- `stall_cnt_o`  out  CNT_W: issue back-pressure cycle count.

## Operation
- FSM states: RUN, EXCP. Reset state is RUN.
- Ready and load:
  - `fetch_ready_o` = (state==RUN) & ~flush_i & (~dec_valid_o | issue_ready_i).
  - `pipe_load_decode_o` = fetch_valid_i & fetch_ready_o.
- `dec_valid_o` update, in priority order:
  - flush_i: cleared.
  - load: set.
  - issue_ready_i: cleared.
  - otherwise: held.
- `dec_way_vld_r0_o`:
  - Loads `fetch_way_vld_i` on load.
  - Cleared on flush.
  - Otherwise held.
- Illegal masking:
  - Define `ill` = illegal_inst_r0_i & dec_way_vld_r0_o.
  - If ill[0]: `issue_vld_o` = 2'b00 and `exc_way_o` = 0.
  - Else if ill[1]: `issue_vld_o` = 2'b01 and `exc_way_o` = 1.
  - Else: `issue_vld_o` = dec_way_vld_r0_o.
  - In all cases `issue_vld_o` is forced to 0 when ~dec_valid_o or state==EXCP.
- RUN→EXCP when dec_valid_o & issue_ready_i & |ill & ~flush_i.
  - `exc_req_o` goes to 1 and `exc_way_o` is latched, both from the next cycle.
  - No further fetch is accepted.
- EXCP→RUN only on flush_i; this clears `exc_req_o` on the next cycle.
- flush_i has priority over every other event in every state.
- Stall counter:
  - Increments when dec_valid_o & ~issue_ready_i & state==RUN.
  - Saturates at all-ones.
  - Cleared only by reset.

## Timing
- Reset values: `dec_valid_o`=0, `dec_way_vld_r0_o`=0, `exc_req_o`=0, `exc_way_o`=0, `stall_cnt_o`=0, state=RUN.
- Combinational outputs are 0 during reset: `fetch_ready_o`, `pipe_load_decode_o`, `issue_vld_o`.
- Fetch-to-r0 latency is 1 cycle. A bundle accepted in cycle N shows `dec_valid_o`=1 in N+1.
- Full throughput: a bundle issued and a new bundle loaded in the same cycle keeps `dec_valid_o`=1 with no bubble.
- Back-pressure:
  - With dec_valid_o=1 and issue_ready_i=0, `fetch_ready_o`=0.
  - r0 contents and `pipe_load_decode_o`=0 are held stable.
- flush_i together with fetch_valid_i: the bundle is not loaded and r0 is empty next cycle.
- flush_i in the same cycle as an illegal bundle issues: no EXCP entry.
- reset_n asserted mid-operation clears all state asynchronously. No partial bundle survives.

## Configuration
- Macro `DEC_STALL_CNT_EN`.
- Defined: the stall counter of width `CNT_W` is implemented as above.
- Undefined: no counter flops exist and `stall_cnt_o` is tied to 0.
- Handshake behaviour is identical in both builds.

## Test plan
- Reset, then fetch_valid_i=1 with way_vld=2'b11 and issue_ready_i=1 every cycle:
  - `pipe_load_decode_o`=1 each cycle.
  - `dec_valid_o`=1 from cycle 1 with no bubbles.
  - `issue_vld_o`=2'b11.
- Bundle in r0 with issue_ready_i=0 for 5 cycles:
  - `fetch_ready_o`=0 and `dec_way_vld_r0_o` is held.
  - `stall_cnt_o` goes from 0 to 5 (0 if the macro is undefined).
  - Release gives `dec_valid_o`=0 next cycle when fetch is idle.
- illegal_inst_r0_i=2'b10 with way_vld=2'b11 and issue_ready_i=1:
  - `issue_vld_o`=2'b01.
  - Next cycle `exc_req_o`=1, `exc_way_o`=1, `fetch_ready_o`=0.
  - flush_i for 1 cycle clears `exc_req_o` next cycle and resumes RUN.
- illegal_inst_r0_i=2'b01:
  - `issue_vld_o`=2'b00 and `exc_way_o`=0.
- flush_i and fetch_valid_i together while r0 is valid:
  - `pipe_load_decode_o`=0.
  - Next cycle `dec_valid_o`=0 and `dec_way_vld_r0_o`=2'b00.
- reset_n low mid-stall with the counter at 7:
  - All outputs return to reset values asynchronously, including `stall_cnt_o`=0.

Source files
------------

// File: rtl/dec_ctrl.sv
// Decode-stage pipeline controller: bundle valid/ready handshake, illegal-way masking, exception hold.
// Optional issue back-pressure stall counter enabled by DEC_STALL_CNT_EN.
module dec_ctrl #(
  parameter int WAYS  = 2,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             fetch_valid_i,
  input  logic [WAYS-1:0]  fetch_way_vld_i,
  output logic             fetch_ready_o,
  output logic             pipe_load_decode_o,
  input  logic [WAYS-1:0]  illegal_inst_r0_i,
  output logic             dec_valid_o,
  output logic [WAYS-1:0]  dec_way_vld_r0_o,
  output logic [WAYS-1:0]  issue_vld_o,
  input  logic             issue_ready_i,
  input  logic             flush_i,
  output logic             exc_req_o,
  output logic             exc_way_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {RUN = 1'b0, EXCP = 1'b1} state_e;

  state_e          r_state;
  state_e          w_next_state;
  logic            r_dec_valid;
  logic [WAYS-1:0] r_way_vld;
  logic            r_exc_way;
  logic            w_ready;
  logic            w_load;
  logic [WAYS-1:0] w_ill;
  logic [WAYS-1:0] w_issue_vld;
  logic            w_exc_way;
  logic            w_take_exc;

  // Reset gating keeps the handshake outputs quiet while reset_n is held low.
  assign w_ready = reset_n & (r_state == RUN) & ~flush_i & (~r_dec_valid | issue_ready_i);
  assign w_load  = fetch_valid_i & w_ready;
  assign w_ill   = illegal_inst_r0_i & r_way_vld;

  always_comb begin
    w_issue_vld  = r_way_vld;
    w_exc_way    = 1'b0;
    w_take_exc   = 1'b0;
    w_next_state = r_state;
    if (w_ill[0]) begin
      w_issue_vld = '0;
      w_exc_way   = 1'b0;
    end else if (w_ill[1]) begin
      w_issue_vld = 2'b01;
      w_exc_way   = 1'b1;
    end
    if (!r_dec_valid || r_state == EXCP) begin
      w_issue_vld = '0;
    end
    case (r_state)
      RUN: begin
        if (r_dec_valid && issue_ready_i && (|w_ill) && !flush_i) begin
          w_take_exc   = 1'b1;
          w_next_state = EXCP;
        end
      end
      EXCP: begin
        if (flush_i) begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_dec_valid <= 1'b0;
      r_way_vld   <= '0;
      r_exc_way   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (flush_i) begin
        r_dec_valid <= 1'b0;
        r_way_vld   <= '0;
      end else if (w_load) begin
        r_dec_valid <= 1'b1;
        r_way_vld   <= fetch_way_vld_i;
      end else if (issue_ready_i) begin
        r_dec_valid <= 1'b0;
      end
      if (w_take_exc) begin
        r_exc_way <= w_exc_way;
      end
    end
  end

`ifdef DEC_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall_inc;

  assign w_stall_inc = r_dec_valid & ~issue_ready_i & (r_state == RUN);

  // Saturating count; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  assign fetch_ready_o      = w_ready;
  assign pipe_load_decode_o = w_load;
  assign dec_valid_o        = r_dec_valid;
  assign dec_way_vld_r0_o   = r_way_vld;
  assign issue_vld_o        = w_issue_vld;
  assign exc_req_o          = (r_state == EXCP);
  assign exc_way_o          = r_exc_way;

endmodule
